// File: rtl/jedro_1_dmem_arb_pkg.sv
// Shared types for the jedro_1 data-memory arbiter.
package jedro_1_dmem_arb_pkg;

  // Widest request fields the arbiter carries internally; narrower ports are zero-extended.
  localparam int unsigned DMEM_MAX_ADDR_W = 64;
  localparam int unsigned DMEM_MAX_DATA_W = 64;
  localparam int unsigned DMEM_MAX_BE_W   = DMEM_MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } dmem_arb_state_e;

  typedef struct packed {
    logic [DMEM_MAX_BE_W-1:0]   we;
    logic [DMEM_MAX_ADDR_W-1:0] addr;
    logic [DMEM_MAX_DATA_W-1:0] wdata;
  } dmem_req_t;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_ACK,
    RESP_ERR
  } dmem_resp_e;

endpackage

// File: rtl/jedro_1_rr_arbiter2.sv
// Two-way round-robin grant with a last-grant pointer.
module jedro_1_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] grant_c
);

  logic last_grant;

  // One-hot grant; on a tie the master not granted last wins.
  always_comb begin
    grant_c = 2'b00;
    if (req[0] && (!req[1] || last_grant)) begin
      grant_c = 2'b01;
    end else if (req[1]) begin
      grant_c = 2'b10;
    end
  end

  // Remember who was granted so the other side wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (update_en && (|grant_c)) begin
      last_grant <= grant_c[1];
    end
  end

endmodule

// File: rtl/jedro_1_dmem_arbiter.sv
// Two-master data-memory arbiter: round-robin grant, single-pulse slave request,
// timeout-to-error, and response routing back to the granted master.
module jedro_1_dmem_arbiter
  import jedro_1_dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  input  logic [DATA_WIDTH/8-1:0] m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_req_i,
  input  logic [DATA_WIDTH/8-1:0] m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    s_req_o,
  output logic [DATA_WIDTH/8-1:0] s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES);

  dmem_arb_state_e  state;
  logic             gnt_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant_c;
  dmem_req_t        sel_c;
  dmem_resp_e       resp_c;

  jedro_1_rr_arbiter2 u_rr (
    .clk       (clk_i),
    .rst       (rst_i),
    .req       ({m1_req_i, m0_req_i}),
    .update_en (state == ST_IDLE),
    .grant_c   (grant_c)
  );

  // Request fields of whichever master the arbiter currently selects.
  always_comb begin
    sel_c.we    = DMEM_MAX_BE_W'(m0_we_i);
    sel_c.addr  = DMEM_MAX_ADDR_W'(m0_addr_i);
    sel_c.wdata = DMEM_MAX_DATA_W'(m0_wdata_i);
    if (grant_c[1]) begin
      sel_c.we    = DMEM_MAX_BE_W'(m1_we_i);
      sel_c.addr  = DMEM_MAX_ADDR_W'(m1_addr_i);
      sel_c.wdata = DMEM_MAX_DATA_W'(m1_wdata_i);
    end
  end

  // Response decode while a transaction is outstanding; error beats ack, timeout is an error.
  always_comb begin
    resp_c = RESP_NONE;
    if (state == ST_ISSUE || state == ST_WAIT) begin
      if (s_err_i) begin
        resp_c = RESP_ERR;
      end else if (s_ack_i) begin
        resp_c = RESP_ACK;
      end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        resp_c = RESP_ERR;
      end
    end
  end

  // Sequencer FSM with registered slave and master outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      gnt_q      <= 1'b0;
      cnt        <= '0;
      s_req_o    <= 1'b0;
      s_we_o     <= '0;
      s_addr_o   <= '0;
      s_wdata_o  <= '0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_rdata_o <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_rdata_o <= '0;
    end else begin
      s_req_o    <= 1'b0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_rdata_o <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_rdata_o <= '0;
      case (state)
        ST_IDLE: begin
          if (|grant_c) begin
            s_we_o    <= BE_WIDTH'(sel_c.we);
            s_addr_o  <= ADDR_WIDTH'(sel_c.addr);
            s_wdata_o <= DATA_WIDTH'(sel_c.wdata);
            gnt_q     <= grant_c[1];
            cnt       <= '0;
            s_req_o   <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (resp_c != RESP_NONE) begin
            state <= ST_RESP;
            if (gnt_q) begin
              m1_ack_o <= (resp_c == RESP_ACK);
              m1_err_o <= (resp_c == RESP_ERR);
              if (resp_c == RESP_ACK) m1_rdata_o <= s_rdata_i;
            end else begin
              m0_ack_o <= (resp_c == RESP_ACK);
              m0_err_o <= (resp_c == RESP_ERR);
              if (resp_c == RESP_ACK) m0_rdata_o <= s_rdata_i;
            end
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= ST_WAIT;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_dmem_arbiter.sv
// Directed bench for jedro_1_dmem_arbiter: per-cycle vector table plus hand sequences.
module tb_jedro_1_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m1_req_i;
  logic [3:0]  m0_we_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_req_o;
  logic [3:0]  s_we_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic        s_ack_i, s_err_i;

  int checks = 0;
  int errors = 0;

  jedro_1_dmem_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .m0_req_i   (m0_req_i),
    .m0_we_i    (m0_we_i),
    .m0_addr_i  (m0_addr_i),
    .m0_wdata_i (m0_wdata_i),
    .m0_rdata_o (m0_rdata_o),
    .m0_ack_o   (m0_ack_o),
    .m0_err_o   (m0_err_o),
    .m1_req_i   (m1_req_i),
    .m1_we_i    (m1_we_i),
    .m1_addr_i  (m1_addr_i),
    .m1_wdata_i (m1_wdata_i),
    .m1_rdata_o (m1_rdata_o),
    .m1_ack_o   (m1_ack_o),
    .m1_err_o   (m1_err_o),
    .s_req_o    (s_req_o),
    .s_we_o     (s_we_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_rdata_i  (s_rdata_i),
    .s_ack_i    (s_ack_i),
    .s_err_i    (s_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        m0r;
    logic        m1r;
    logic [3:0]  m0we;
    logic [31:0] m0addr;
    logic [3:0]  m1we;
    logic [31:0] m1addr;
    logic [31:0] wd;
    logic        sack;
    logic        serr;
    logic [31:0] srd;
    logic        e_sreq;
    logic [3:0]  e_swe;
    logic [31:0] e_saddr;
    logic [31:0] e_swd;
    logic        e_m0ack;
    logic        e_m0err;
    logic [31:0] e_m0rd;
    logic        e_m1ack;
    logic        e_m1err;
    logic [31:0] e_m1rd;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sreq"}, 32'(s_req_o), 32'd0);
    chk({tag, "_swe"}, 32'(s_we_o), 32'd0);
    chk({tag, "_saddr"}, s_addr_o, 32'd0);
    chk({tag, "_swdata"}, s_wdata_o, 32'd0);
    chk({tag, "_m0"}, {30'd0, m0_ack_o, m0_err_o}, 32'd0);
    chk({tag, "_m1"}, {30'd0, m1_ack_o, m1_err_o}, 32'd0);
    chk({tag, "_m0rd"}, m0_rdata_o, 32'd0);
    chk({tag, "_m1rd"}, m1_rdata_o, 32'd0);
  endtask

  // Wait for the slave request, answer one cycle later, check routing of the ack.
  task automatic do_txn(input int exp_m, input logic [31:0] exp_addr, input logic [31:0] rd);
    int n = 0;
    while (s_req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("txn%0d_sreq", exp_m), 32'(s_req_o), 32'd1);
    chk($sformatf("txn%0d_addr", exp_m), s_addr_o, exp_addr);
    tick();
    s_ack_i = 1'b1;
    s_rdata_i = rd;
    tick();
    s_ack_i = 1'b0;
    s_rdata_i = 32'd0;
    if (exp_m == 0) begin
      chk("txn0_ack", {30'd0, m0_ack_o, m0_err_o}, 32'd2);
      chk("txn0_rdata", m0_rdata_o, rd);
      chk("txn0_other", {30'd0, m1_ack_o, m1_err_o}, 32'd0);
    end else begin
      chk("txn1_ack", {30'd0, m1_ack_o, m1_err_o}, 32'd2);
      chk("txn1_rdata", m1_rdata_o, rd);
      chk("txn1_other", {30'd0, m0_ack_o, m0_err_o}, 32'd0);
    end
  endtask

  initial begin
    bit seen;
    rst_i = 1'b1;
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    m0_we_i = 4'h0; m1_we_i = 4'h0;
    m0_addr_i = 32'd0; m1_addr_i = 32'd0;
    m0_wdata_i = 32'd0; m1_wdata_i = 32'd0;
    s_rdata_i = 32'd0; s_ack_i = 1'b0; s_err_i = 1'b0;

    // m0 load, ack 1 cycle after s_req
    vq.push_back('{1'b1,1'b0,4'h0,32'h10,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    vq.push_back('{1'b1,1'b0,4'h0,32'h10,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b1,4'h0,32'h10,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    vq.push_back('{1'b1,1'b0,4'h0,32'h10,4'h0,32'h0,32'h0,1'b1,1'b0,32'hDEADBEEF, 1'b0,4'h0,32'h10,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    vq.push_back('{1'b1,1'b0,4'h0,32'h10,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h10,32'h0,1'b1,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h0});
    vq.push_back('{1'b0,1'b0,4'h0,32'h0,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h10,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    // m1 store, slave error
    vq.push_back('{1'b0,1'b1,4'h0,32'h0,4'hF,32'h20,32'h12345678,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h10,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    vq.push_back('{1'b0,1'b1,4'h0,32'h0,4'hF,32'h20,32'h12345678,1'b0,1'b0,32'h0, 1'b1,4'hF,32'h20,32'h12345678,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    vq.push_back('{1'b0,1'b1,4'h0,32'h0,4'hF,32'h20,32'h12345678,1'b0,1'b1,32'h0, 1'b0,4'hF,32'h20,32'h12345678,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    vq.push_back('{1'b0,1'b1,4'h0,32'h0,4'hF,32'h20,32'h12345678,1'b0,1'b0,32'h0, 1'b0,4'hF,32'h20,32'h12345678,1'b0,1'b0,32'h0,1'b0,1'b1,32'h0});
    vq.push_back('{1'b0,1'b0,4'h0,32'h0,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,4'hF,32'h20,32'h12345678,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    // m0 load, ack+err together in ISSUE -> error, rdata 0
    vq.push_back('{1'b1,1'b0,4'h0,32'h30,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,4'hF,32'h20,32'h12345678,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    vq.push_back('{1'b1,1'b0,4'h0,32'h30,4'h0,32'h0,32'h0,1'b1,1'b1,32'hCAFEF00D, 1'b1,4'h0,32'h30,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    vq.push_back('{1'b1,1'b0,4'h0,32'h30,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h30,32'h0,1'b0,1'b1,32'h0,1'b0,1'b0,32'h0});
    // stray responses in IDLE are ignored
    vq.push_back('{1'b0,1'b0,4'h0,32'h0,4'h0,32'h0,32'h0,1'b1,1'b0,32'h11111111, 1'b0,4'h0,32'h30,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    vq.push_back('{1'b0,1'b0,4'h0,32'h0,4'h0,32'h0,32'h0,1'b0,1'b1,32'h0, 1'b0,4'h0,32'h30,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    // m1 load, ack in ISSUE -> ack 2 cycles after request
    vq.push_back('{1'b0,1'b1,4'h0,32'h0,4'h0,32'h40,32'h0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h30,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    vq.push_back('{1'b0,1'b1,4'h0,32'h0,4'h0,32'h40,32'h0,1'b1,1'b0,32'hA5A5A5A5, 1'b1,4'h0,32'h40,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});
    vq.push_back('{1'b0,1'b1,4'h0,32'h0,4'h0,32'h40,32'h0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h40,32'h0,1'b0,1'b0,32'h0,1'b1,1'b0,32'hA5A5A5A5});
    vq.push_back('{1'b0,1'b0,4'h0,32'h0,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,4'h0,32'h40,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0});

    tick();
    tick();
    chk_all_zero("reset");
    rst_i = 1'b0;

    foreach (vq[i]) begin
      chk($sformatf("v%0d_sreq", i), 32'(s_req_o), 32'(vq[i].e_sreq));
      chk($sformatf("v%0d_swe", i), 32'(s_we_o), 32'(vq[i].e_swe));
      chk($sformatf("v%0d_saddr", i), s_addr_o, vq[i].e_saddr);
      chk($sformatf("v%0d_swdata", i), s_wdata_o, vq[i].e_swd);
      chk($sformatf("v%0d_m0", i), {30'd0, m0_ack_o, m0_err_o}, {30'd0, vq[i].e_m0ack, vq[i].e_m0err});
      chk($sformatf("v%0d_m0rd", i), m0_rdata_o, vq[i].e_m0rd);
      chk($sformatf("v%0d_m1", i), {30'd0, m1_ack_o, m1_err_o}, {30'd0, vq[i].e_m1ack, vq[i].e_m1err});
      chk($sformatf("v%0d_m1rd", i), m1_rdata_o, vq[i].e_m1rd);
      m0_req_i = vq[i].m0r;     m1_req_i = vq[i].m1r;
      m0_we_i = vq[i].m0we;     m1_we_i = vq[i].m1we;
      m0_addr_i = vq[i].m0addr; m1_addr_i = vq[i].m1addr;
      m0_wdata_i = vq[i].wd;    m1_wdata_i = vq[i].wd;
      s_ack_i = vq[i].sack;     s_err_i = vq[i].serr;
      s_rdata_i = vq[i].srd;
      tick();
    end

    // Round robin with both masters requesting continuously from reset
    rst_i = 1'b1;
    tick();
    chk_all_zero("rr_reset");
    rst_i = 1'b0;
    m0_req_i = 1'b1; m0_addr_i = 32'h0;
    m1_req_i = 1'b1; m1_addr_i = 32'h100;
    do_txn(0, 32'h0, 32'h0000_0A00);
    do_txn(1, 32'h100, 32'h0000_0A01);
    do_txn(0, 32'h0, 32'h0000_0A02);
    do_txn(1, 32'h100, 32'h0000_0A03);
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    tick();

    // Timeout: silent slave, error 17 cycles after the request cycle
    m0_req_i = 1'b1; m0_addr_i = 32'h50;
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) chk("to_sreq", 32'(s_req_o), 32'd1);
      if (m0_err_o || m0_ack_o || m1_err_o || m1_ack_o) seen = 1'b1;
    end
    chk("to_no_early_pulse", 32'(seen), 32'd0);
    tick();
    chk("to_err", {30'd0, m0_ack_o, m0_err_o}, 32'd1);
    chk("to_rdata", m0_rdata_o, 32'd0);
    chk("to_other", {30'd0, m1_ack_o, m1_err_o}, 32'd0);
    m0_req_i = 1'b0;
    tick();
    tick();
    tick();
    s_ack_i = 1'b1; s_rdata_i = 32'h77777777;
    tick();
    s_ack_i = 1'b0; s_rdata_i = 32'd0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (m0_err_o || m0_ack_o || m1_err_o || m1_ack_o) seen = 1'b1;
      tick();
    end
    chk("to_late_ack_dropped", 32'(seen), 32'd0);

    // Reset during WAIT abandons the transaction
    m0_req_i = 1'b1; m0_addr_i = 32'h60;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst_i = 1'b0;
    m0_req_i = 1'b0;
    s_ack_i = 1'b1; s_rdata_i = 32'h99999999;
    tick();
    s_ack_i = 1'b0; s_rdata_i = 32'd0;
    chk("midrst_no_pulse", {28'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'd0);
    chk("midrst_no_sreq", 32'(s_req_o), 32'd0);
    m0_req_i = 1'b1; m1_req_i = 1'b1; m1_addr_i = 32'h70;
    do_txn(0, 32'h60, 32'h0000_0B00);
    m0_req_i = 1'b0;
    do_txn(1, 32'h70, 32'h0000_0B01);
    m1_req_i = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
